// File: rtl/stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn
//
// Registered 1-to-N stream demultiplexer. Each accepted input word is routed to
// the channel named by sel, or to every channel when bcast is set. Each output
// channel owns a one-entry register (data + valid). A word whose sel names no
// existing channel is accepted and discarded, and the discard is reported on
// drop_pulse and counted in a saturating drop_cnt.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until ready=1.
// in_ready may be used combinationally by the producer. out_valid/dout come
// straight from registers, and they stay stable while out_ready is low.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   in_valid    input word valid
//   in_ready    input word accepted this cycle (combinational)
//   din         input data word
//   sel         destination channel, sampled with din
//   bcast       1 = load every channel, sel ignored
//   dout        channel i data at [i*DATA_W +: DATA_W]
//   out_valid   per-channel data valid (this is also the per-channel full bit)
//   out_ready   per-channel consumer ready
//   drop_pulse  one-cycle pulse after an out-of-range word was discarded
//   drop_cnt    saturating count of discarded words
// ---------------------------------------------------------------------------
module stream_demux_1xn #(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     bcast,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] free;     // slot empty, or draining this cycle
    logic [NUM_CH-1:0] sel_hit;  // one-hot decode of sel over existing channels
    logic [NUM_CH-1:0] load;     // channels that capture din on the next edge
    logic              sel_ok;   // sel names an existing channel
    logic              accept;
    logic              drop;

    always_comb begin
        free    = ~out_valid | out_ready;
        sel_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_hit[i] = (32'(sel) == i);
        end
        sel_ok = |sel_hit;

        // A unicast only waits on its own channel. An out-of-range word has
        // nowhere to wait, so it is always sunk.
        if (bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = |(sel_hit & free);
        end else begin
            in_ready = 1'b1;
        end

        accept = in_valid & in_ready;
        load   = {NUM_CH{accept}} & (bcast ? {NUM_CH{1'b1}} : sel_hit);
        drop   = accept & ~bcast & ~sel_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= '0;
            dout       <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A load in the same cycle as a drain takes priority, so the
                // channel refills without a bubble.
                if (load[i]) begin
                    dout[i*DATA_W +: DATA_W] <= din;
                    out_valid[i]             <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            drop_pulse <= drop;
            if (drop && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1xn
//
// Instance a: 4 channels, 8-bit drop counter. Driven through drive_a, which
// predicts in_ready from the words currently held per channel and pushes every
// accepted word onto the expected queue of each destination channel. A
// separate monitor pops a word each time a channel completes a handshake, and
// checks out_valid and dout against the queue heads.
// Instance b: 3 channels, 2-bit drop counter. Exercises out-of-range drops,
// counter saturation and reset of the counter.
// ---------------------------------------------------------------------------
module tb_stream_demux_1xn;

    localparam int DW = 4;
    localparam int NA = 4;
    localparam int NB = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             a_rst_n, a_in_valid, a_in_ready, a_bcast, a_drop_pulse;
    logic [DW-1:0]    a_din;
    logic [1:0]       a_sel;
    logic [NA*DW-1:0] a_dout;
    logic [NA-1:0]    a_out_valid, a_out_ready;
    logic [7:0]       a_drop_cnt;

    logic             b_rst_n, b_in_valid, b_in_ready, b_bcast, b_drop_pulse;
    logic [DW-1:0]    b_din;
    logic [1:0]       b_sel;
    logic [NB*DW-1:0] b_dout;
    logic [NB-1:0]    b_out_valid, b_out_ready;
    logic [1:0]       b_drop_cnt;

    stream_demux_1xn #(.DATA_W(DW), .NUM_CH(NA), .SEL_W(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din(a_din), .sel(a_sel), .bcast(a_bcast), .dout(a_dout),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt)
    );

    stream_demux_1xn #(.DATA_W(DW), .NUM_CH(NB), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din(b_din), .sel(b_sel), .bcast(b_bcast), .dout(b_dout),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int b_drops = 0;
    logic [DW-1:0] exp_q [NA][$];
    bit just_pushed [NA];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives one cycle on instance a. Words held per channel are exactly the
    // queue contents at this point, so a channel is free if its queue is
    // empty or its consumer is ready.
    task automatic drive_a(input logic v, input logic [1:0] s, input logic bc,
                           input logic [DW-1:0] d, input logic [NA-1:0] rdy);
        logic [NA-1:0] fr;
        logic          exp_rdy;
        @(negedge clk);
        a_in_valid  = v;
        a_sel       = s;
        a_bcast     = bc;
        a_din       = d;
        a_out_ready = rdy;
        #1;
        for (int i = 0; i < NA; i++) fr[i] = (exp_q[i].size() == 0) || rdy[i];
        exp_rdy = bc ? (&fr) : fr[s];
        check("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            for (int i = 0; i < NA; i++) begin
                if (bc || (int'(s) == i)) begin
                    exp_q[i].push_back(d);
                    just_pushed[i] = 1'b1;
                end
            end
        end
    endtask

    // One word into instance b with all consumers ready, then checks the
    // following two cycles.
    task automatic b_word(input logic [1:0] s, input logic bc, input logic [DW-1:0] d);
        logic [NB-1:0] ev;
        logic          is_drop;
        int            exp_cnt;
        ev = '0;
        for (int i = 0; i < NB; i++) if (bc || (int'(s) == i)) ev[i] = 1'b1;
        is_drop = !bc && (int'(s) >= NB);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_sel      = s;
        b_bcast    = bc;
        b_din      = d;
        #1;
        check("b_in_ready", 32'(b_in_ready), 32'd1);
        if (is_drop) b_drops++;
        exp_cnt = (b_drops > 3) ? 3 : b_drops;
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        check("b_out_valid", 32'(b_out_valid), 32'(ev));
        check("b_drop_pulse", 32'(b_drop_pulse), 32'(is_drop));
        check("b_drop_cnt", 32'(b_drop_cnt), 32'(exp_cnt));
        for (int i = 0; i < NB; i++) begin
            if (ev[i]) check("b_dout", 32'(b_dout[i*DW +: DW]), 32'(d));
        end
        @(negedge clk);
        #1;
        check("b_drop_pulse_end", 32'(b_drop_pulse), 32'd0);
        check("b_out_valid_drain", 32'(b_out_valid), 32'd0);
    endtask

    // ---------------- monitor (instance a) ----------------
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            for (int i = 0; i < NA; i++) begin
                int held;
                // A word pushed this cycle only becomes visible after the edge.
                held = exp_q[i].size() - (just_pushed[i] ? 1 : 0);
                check("a_out_valid", 32'(a_out_valid[i]), 32'(held > 0));
                if (a_out_valid[i] && (held > 0)) begin
                    check("a_dout", 32'(a_dout[i*DW +: DW]), 32'(exp_q[i][0]));
                    if (a_out_ready[i]) void'(exp_q[i].pop_front());
                end
                just_pushed[i] = 1'b0;
            end
            check("a_drop_pulse", 32'(a_drop_pulse), 32'd0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_sel = '0; a_bcast = 1'b0; a_din = '0; a_out_ready = '0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_sel = '0; b_bcast = 1'b0; b_din = '0; b_out_ready = '1;
        for (int i = 0; i < NA; i++) just_pushed[i] = 1'b0;
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;
        check("a_reset_valid", 32'(a_out_valid), 32'd0);
        check("a_reset_dout", a_dout, 32'd0);
        check("a_reset_cnt", 32'(a_drop_cnt), 32'd0);
        check("b_reset_valid", 32'(b_out_valid), 32'd0);
        check("b_reset_pulse", 32'(b_drop_pulse), 32'd0);
        mon_en = 1'b1;

        // Unicast sweep over all channels, every consumer ready.
        for (int k = 0; k < 15; k++) drive_a(1'b1, 2'(k % 4), 1'b0, 4'(k + 1), 4'hF);
        drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

        // Backpressure on channel 2, then release with no bubble.
        drive_a(1'b1, 2'd2, 1'b0, 4'h3, 4'b1011);
        drive_a(1'b1, 2'd2, 1'b0, 4'h7, 4'b1011);
        drive_a(1'b1, 2'd2, 1'b0, 4'h7, 4'b1011);
        drive_a(1'b1, 2'd2, 1'b0, 4'h7, 4'hF);
        drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

        // Channel 1 stalled full does not block a unicast to channel 0.
        drive_a(1'b1, 2'd1, 1'b0, 4'h9, 4'b1101);
        drive_a(1'b1, 2'd0, 1'b0, 4'h4, 4'b1101);

        // Broadcast waits for the stalled channel, then lands everywhere.
        drive_a(1'b1, 2'd0, 1'b1, 4'hA, 4'b1101);
        drive_a(1'b1, 2'd3, 1'b1, 4'hA, 4'b1101);
        drive_a(1'b1, 2'd3, 1'b1, 4'hA, 4'hF);
        repeat (2) drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

        // Randomised traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            drive_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                    4'($urandom) | 4'($urandom));
        end
        repeat (3) drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);
        for (int i = 0; i < NA; i++) check("a_drained", 32'(exp_q[i].size()), 32'd0);

        // Reset while every channel is full and stalled.
        drive_a(1'b1, 2'd0, 1'b1, 4'hC, 4'h0);
        drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        a_rst_n     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = '0;
        #3;
        for (int i = 0; i < NA; i++) begin
            exp_q[i].delete();
            just_pushed[i] = 1'b0;
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        #1;
        check("a_midreset_valid", 32'(a_out_valid), 32'd0);
        check("a_midreset_dout", a_dout, 32'd0);
        check("a_midreset_cnt", 32'(a_drop_cnt), 32'd0);
        drive_a(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

        // Instance b: out-of-range drops and counter saturation.
        b_word(2'd3, 1'b0, 4'h5);
        for (int k = 0; k < 4; k++) b_word(2'd3, 1'b0, 4'($urandom_range(0, 15)));
        for (int k = 0; k < 20; k++) begin
            b_word(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
        end

        // Counter clears on reset.
        @(negedge clk);
        b_rst_n = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        #1;
        check("b_reset_cnt", 32'(b_drop_cnt), 32'd0);
        check("b_reset_dout", 32'(b_dout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
